mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single Pmmu memory port between the CPU control path (port 0) and the console/debug loader (port 1). Each requester issues one memory access per grant. The arbiter latches the command, drives the Pmmu strobes, and waits for `mem_rdy`. It then returns read data with a one-cycle acknowledge. It sits between `ControlMatrix`/address mux on one side and `Pmmu` on the other, and includes a timeout guard for a hung memory.

## Interface
- DATA_WIDTH, 32, width of address, write data and read data
- TIMEOUT, 255, max WAIT cycles before an access is aborted (1..65535)

- clk_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  in  1  access request, level; held until ack
- m0_wr_i / m1_wr_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  DATA_WIDTH  byte address
- m0_wd_i / m1_wd_i  in  DATA_WIDTH  write data
- m0_funct3_i / m1_funct3_i  in  3  access size/sign code, passed to Pmmu
- m0_gnt_o / m1_gnt_o  out  1  port owns memory (ISSUE..DONE)
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- rd_o  out  DATA_WIDTH  registered read data, valid with ack
- err_o  out  1  one-cycle pulse coincident with ack on timeout
- mem_addr_o  out  DATA_WIDTH  to Pmmu byte_addr_i
- mem_wd_o  out  DATA_WIDTH  to Pmmu wd_i
- mem_funct3_o  out  3  to Pmmu funct3
- mem_wr_o / mem_rd_o  out  1  Pmmu strobes
- mem_rd_i  in  DATA_WIDTH  Pmmu rd_o
- mem_rdy_i  in  1  Pmmu mem_rdy_o

## Operation
States: IDLE, ISSUE, WAIT, DONE (2-bit encoding).

- **IDLE**
  - If no request, stay.
  - If exactly one request, grant that port.
  - If both request, apply the tie rule.
  - On grant edge: latch the winner's wr/addr/wd/funct3 into internal command registers, set `owner`, go to ISSUE.
- **ISSUE**
  - `gnt` high for `owner`.
  - `mem_wr_o` = latched wr; `mem_rd_o` = !latched wr.
  - Address, write data and funct3 driven from the command registers.
  - Go to WAIT; load the timeout counter with 0.
- **WAIT**
  - Strobes low; address, write data and funct3 held.
  - If `mem_rdy_i` = 1 at the edge: capture `mem_rd_i` into `rd_o` (reads only; writes leave `rd_o` unchanged), go to DONE.
  - Else increment the counter. When the counter reaches TIMEOUT: set `rd_o` = 0, flag the error, go to DONE.
- **DONE**
  - `ack` high for `owner`, `gnt` still high.
  - `err_o` high if the access timed out.
  - Set `last` = `owner`, go to IDLE.
- Tie rule (round-robin): the port not equal to `last` wins. Reset value of `last` = 1, so the CPU wins the first tie.
- Command inputs are don't-care after the grant edge. The requester may change them or drop `req`; the access still completes and `ack` still pulses.
- A requester whose `req` is still high after its `ack` is treated as a new request in IDLE. It loses a tie to the other port (round-robin), so no starvation.
- The counter width is sized to hold TIMEOUT; the counter does not wrap.

## Timing
- Reset (async assert, sync release): state IDLE, all gnt/ack/err/strobes 0, mem_addr/wd/funct3 0, rd_o 0, `last` = 1, counter 0.
- Reset asserted mid-access: the access is abandoned, no ack is produced, and outputs go to reset values immediately.
- `req` sampled high at edge k → ISSUE cycle k..k+1 (gnt and strobe visible after edge k).
- `mem_rdy_i` high in the first WAIT cycle → ack after edge k+2. Minimum request-to-ack latency is 3 cycles; back-to-back access period is 4 cycles.
- `mem_rdy_i` ignored outside WAIT.
- Timeout: ack/err after TIMEOUT+2 cycles from grant.
- All outputs are registered or decoded from registered state only; no combinational path from `req` to `gnt`.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: round-robin disabled; port 1 (debug) always wins ties, and `last` is unused. This lets the console freeze the CPU's memory traffic while loading.
- `ARB_FIXED_PRIO_EN` undefined: round-robin as above.

## Test plan
- **Single read, port 0:** addr 0x40, funct3 3'b010, `mem_rdy_i` high in the first WAIT with `mem_rd_i` 0xDEADBEEF → `m0_gnt_o` for 3 cycles, `mem_rd_o` 1 for 1 cycle, `m0_ack_o` at cycle 3, `rd_o` = 0xDEADBEEF, `err_o` 0.
- **Simultaneous requests after reset, held high through 4 accesses:** grant order 0,1,0,1; each ack on the matching port; with `ARB_FIXED_PRIO_EN` the order is 1,1,1,1.
- **Port 1 write:** addr 0x100, wd 0x12345678; inputs changed to garbage one cycle after grant → `mem_addr_o`/`mem_wd_o` hold the latched values through WAIT; `mem_wr_o` pulses once; `rd_o` unchanged.
- **Timeout:** `mem_rdy_i` held 0, TIMEOUT = 4 → ack plus `err_o` pulse 6 cycles after grant, `rd_o` = 0, state returns to IDLE.
- **Reset mid-WAIT:** `reset_i` driven low → gnt, ack, strobes and `rd_o` go to 0 immediately; after release a new port-0 request completes normally in 3 cycles.
- **Dropped request:** `req` deasserted in ISSUE → the access still completes and the ack pulses; no second grant follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter that shares the single Pmmu memory port
// between the CPU control path (port 0) and the console/debug loader (port 1).
// A granted access is latched, issued to Pmmu with a one-cycle strobe, waits
// for mem_rdy_i (bounded by TIMEOUT), then acknowledges with a one-cycle pulse.
//
// Optional build macro:
//   ARB_FIXED_PRIO_EN - ties always go to port 1 (debug) instead of round-robin.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  m0_req_i,
    input  logic                  m0_wr_i,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wd_i,
    input  logic [2:0]            m0_funct3_i,
    output logic                  m0_gnt_o,
    output logic                  m0_ack_o,

    input  logic                  m1_req_i,
    input  logic                  m1_wr_i,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wd_i,
    input  logic [2:0]            m1_funct3_i,
    output logic                  m1_gnt_o,
    output logic                  m1_ack_o,

    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  err_o,

    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    input  logic                  mem_rdy_i
);

    // Counter only needs to reach TIMEOUT; it never wraps.
    localparam int unsigned      CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  owner;        // 0 = CPU port, 1 = debug port
    logic                  cmd_wr;
    logic [DATA_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wd;
    logic [2:0]            cmd_funct3;
    logic                  timed_out;
    logic [CNT_W-1:0]      count;

    logic                  take;         // a grant happens at this edge
    logic                  winner;       // port granted at this edge
    logic                  tie_winner;   // port that wins when both request
    logic                  timeout_hit;  // WAIT gives up at this edge

`ifdef ARB_FIXED_PRIO_EN
    // Debug port always wins a tie so the console can freeze CPU traffic.
    assign tie_winner = 1'b1;
`else
    logic last;                          // owner of the most recent access

    assign tie_winner = ~last;

    // Round-robin history: remember who was served last; CPU wins first tie.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last <= 1'b1;
        end else if (state == DONE) begin
            last <= owner;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, grant selection and timeout detection.
    always_comb begin
        next_state  = state;
        take        = 1'b0;
        winner      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    take       = 1'b1;
                    next_state = ISSUE;
                    if (m0_req_i && m1_req_i) begin
                        winner = tie_winner;
                    end else begin
                        winner = m1_req_i;
                    end
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (mem_rdy_i) begin
                    next_state = DONE;
                end else if (count == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command latch: the winner's command is captured on the grant edge so
    // the requester may change its inputs or drop req afterwards.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner      <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wd     <= '0;
            cmd_funct3 <= '0;
        end else if (take) begin
            owner      <= winner;
            cmd_wr     <= winner ? m1_wr_i     : m0_wr_i;
            cmd_addr   <= winner ? m1_addr_i   : m0_addr_i;
            cmd_wd     <= winner ? m1_wd_i     : m0_wd_i;
            cmd_funct3 <= winner ? m1_funct3_i : m0_funct3_i;
        end
    end

    // Wait counter, read-data capture and timeout flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count     <= '0;
            timed_out <= 1'b0;
            rd_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        timed_out <= 1'b0;
                    end
                end
                ISSUE: begin
                    count <= '0;
                end
                WAIT: begin
                    if (mem_rdy_i) begin
                        if (!cmd_wr) begin
                            rd_o <= mem_rd_i;
                        end
                    end else if (timeout_hit) begin
                        rd_o      <= '0;
                        timed_out <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    assign m0_gnt_o     = (state != IDLE) && !owner;
    assign m1_gnt_o     = (state != IDLE) &&  owner;
    assign m0_ack_o     = (state == DONE) && !owner;
    assign m1_ack_o     = (state == DONE) &&  owner;
    assign err_o        = (state == DONE) && timed_out;
    assign mem_wr_o     = (state == ISSUE) &&  cmd_wr;
    assign mem_rd_o     = (state == ISSUE) && !cmd_wr;
    assign mem_addr_o   = cmd_addr;
    assign mem_wd_o     = cmd_wd;
    assign mem_funct3_o = cmd_funct3;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter (TIMEOUT = 4).
// Table rows hold the inputs applied before a clock edge and the outputs
// expected just after it; multi-cycle corner cases follow as hand sequences.
module tb_mem_arbiter;

    localparam logic [31:0] A0  = 32'h0000_0040;
    localparam logic [31:0] WD0 = 32'hA5A5_0000;
    localparam logic [2:0]  F0  = 3'b010;
    localparam logic [31:0] A1  = 32'h0000_0100;
    localparam logic [31:0] WD1 = 32'h1234_5678;
    localparam logic [2:0]  F1  = 3'b001;
    localparam logic [31:0] GA  = 32'hFFFF_FFF0;
    localparam logic [31:0] GWD = 32'h0BAD_0BAD;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        m0_req_i, m0_wr_i, m1_req_i, m1_wr_i;
    logic [31:0] m0_addr_i, m0_wd_i, m1_addr_i, m1_wd_i;
    logic [2:0]  m0_funct3_i, m1_funct3_i;
    logic        m0_gnt_o, m0_ack_o, m1_gnt_o, m1_ack_o;
    logic [31:0] rd_o;
    logic        err_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [2:0]  mem_funct3_o;
    logic        mem_wr_o, mem_rd_o;
    logic [31:0] mem_rd_i;
    logic        mem_rdy_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .m0_req_i     (m0_req_i),
        .m0_wr_i      (m0_wr_i),
        .m0_addr_i    (m0_addr_i),
        .m0_wd_i      (m0_wd_i),
        .m0_funct3_i  (m0_funct3_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_ack_o     (m0_ack_o),
        .m1_req_i     (m1_req_i),
        .m1_wr_i      (m1_wr_i),
        .m1_addr_i    (m1_addr_i),
        .m1_wd_i      (m1_wd_i),
        .m1_funct3_i  (m1_funct3_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_ack_o     (m1_ack_o),
        .rd_o         (rd_o),
        .err_o        (err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_funct3_o (mem_funct3_o),
        .mem_wr_o     (mem_wr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_rdy_i    (mem_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    // Control bits: {gnt0, gnt1, ack0, ack1, err, mem_wr, mem_rd}
    typedef struct {
        logic        req0;
        logic        req1;
        logic        rdy;
        logic        garble;
        logic [31:0] mrdata;
        logic [6:0]  exp_ctl;
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic [2:0]  exp_f3;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] ctl();
        return {m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, err_o, mem_wr_o, mem_rd_o};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic r0, input logic r1, input logic rdy, input logic g,
                       input logic [31:0] md, input logic [6:0] c, input logic [31:0] r,
                       input logic [31:0] a, input logic [31:0] w, input logic [2:0] f);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.rdy = rdy; v.garble = g; v.mrdata = md;
        v.exp_ctl = c; v.exp_rd = r; v.exp_addr = a; v.exp_wd = w; v.exp_f3 = f;
        vecs.push_back(v);
    endtask

    // Garbled commands emulate a requester that changes inputs after its grant.
    task automatic drive_cmds(input logic g);
        m0_wr_i     = g;
        m0_addr_i   = g ? GA  : A0;
        m0_wd_i     = g ? GWD : WD0;
        m0_funct3_i = g ? 3'b111 : F0;
        m1_wr_i     = ~g;
        m1_addr_i   = g ? GA  : A1;
        m1_wd_i     = g ? GWD : WD1;
        m1_funct3_i = g ? 3'b111 : F1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        o;
        logic [31:0] d;
        logic [3:0]  order;

        reset_i   = 1'b0;
        m0_req_i  = 1'b0;
        m1_req_i  = 1'b0;
        mem_rdy_i = 1'b0;
        mem_rd_i  = '0;
        drive_cmds(1'b0);

        // ---- reset state ----
        #2;
        chk("reset_ctl", 0, {25'd0, ctl()}, 32'd0);
        chk("reset_rd", 0, rd_o, 32'd0);
        chk("reset_addr", 0, mem_addr_o, 32'd0);
        chk("reset_wd", 0, mem_wd_o, 32'd0);
        chk("reset_f3", 0, {29'd0, mem_funct3_o}, 32'd0);
        step();
        step();
        reset_i = 1'b1;

        // ---- table: simultaneous requests held through 4 accesses ----
`ifdef ARB_FIXED_PRIO_EN
        order = 4'b1111;
`else
        order = 4'b1010;   // bit a = owner of access a: 0,1,0,1
`endif
        r = 32'd0;
        for (int a = 0; a < 4; a++) begin
            o = order[a];
            d = 32'h1000_0000 + 32'(a);
            add(1, 1, 1, 0, d, o ? 7'b0100010 : 7'b1000001, r,
                o ? A1 : A0, o ? WD1 : WD0, o ? F1 : F0);
            add(1, 1, 1, 0, d, o ? 7'b0100000 : 7'b1000000, r,
                o ? A1 : A0, o ? WD1 : WD0, o ? F1 : F0);
            if (!o) r = d;
            add(1, 1, 1, 0, d, o ? 7'b0101000 : 7'b1010000, r,
                o ? A1 : A0, o ? WD1 : WD0, o ? F1 : F0);
            add(1, 1, 1, 0, d, 7'b0000000, r,
                o ? A1 : A0, o ? WD1 : WD0, o ? F1 : F0);
        end

        // ---- table: single read on port 0 ----
        add(1, 0, 0, 0, 32'd0,         7'b1000001, r,            A0, WD0, F0);
        add(1, 0, 0, 0, 32'd0,         7'b1000000, r,            A0, WD0, F0);
        add(1, 0, 1, 0, 32'hDEADBEEF,  7'b1010000, 32'hDEADBEEF, A0, WD0, F0);
        add(0, 0, 0, 0, 32'd0,         7'b0000000, 32'hDEADBEEF, A0, WD0, F0);
        add(0, 0, 1, 0, 32'h7777_7777, 7'b0000000, 32'hDEADBEEF, A0, WD0, F0);

        // ---- table: port 1 write, inputs garbled after the grant ----
        add(0, 1, 0, 0, 32'd0,         7'b0100010, 32'hDEADBEEF, A1, WD1, F1);
        add(0, 1, 0, 1, 32'd0,         7'b0100000, 32'hDEADBEEF, A1, WD1, F1);
        add(0, 1, 0, 1, 32'd0,         7'b0100000, 32'hDEADBEEF, A1, WD1, F1);
        add(0, 1, 1, 1, 32'hBADBAD00,  7'b0101000, 32'hDEADBEEF, A1, WD1, F1);
        add(0, 0, 0, 0, 32'd0,         7'b0000000, 32'hDEADBEEF, A1, WD1, F1);

        foreach (vecs[i]) begin
            m0_req_i  = vecs[i].req0;
            m1_req_i  = vecs[i].req1;
            mem_rdy_i = vecs[i].rdy;
            mem_rd_i  = vecs[i].mrdata;
            drive_cmds(vecs[i].garble);
            step();
            chk("ctl", i, {25'd0, ctl()}, {25'd0, vecs[i].exp_ctl});
            chk("rd", i, rd_o, vecs[i].exp_rd);
            chk("addr", i, mem_addr_o, vecs[i].exp_addr);
            chk("wd", i, mem_wd_o, vecs[i].exp_wd);
            chk("f3", i, {29'd0, mem_funct3_o}, {29'd0, vecs[i].exp_f3});
        end

        // ---- reset mid-WAIT, then a normal port-0 read ----
        drive_cmds(1'b0);
        m0_req_i  = 1'b1;
        mem_rdy_i = 1'b0;
        step();
        chk("rst_issue", 0, {25'd0, ctl()}, {25'd0, 7'b1000001});
        step();
        chk("rst_wait", 0, {25'd0, ctl()}, {25'd0, 7'b1000000});
        reset_i = 1'b0;
        #1;
        chk("rst_async_ctl", 0, {25'd0, ctl()}, 32'd0);
        chk("rst_async_rd", 0, rd_o, 32'd0);
        chk("rst_async_addr", 0, mem_addr_o, 32'd0);
        step();
        chk("rst_held_ctl", 0, {25'd0, ctl()}, 32'd0);
        reset_i = 1'b1;
        step();
        chk("post_rst_issue", 0, {25'd0, ctl()}, {25'd0, 7'b1000001});
        chk("post_rst_addr", 0, mem_addr_o, A0);
        mem_rdy_i = 1'b1;
        mem_rd_i  = 32'h5555_AAAA;
        step();
        chk("post_rst_wait", 0, {25'd0, ctl()}, {25'd0, 7'b1000000});
        step();
        chk("post_rst_done", 0, {25'd0, ctl()}, {25'd0, 7'b1010000});
        chk("post_rst_rd", 0, rd_o, 32'h5555_AAAA);
        m0_req_i  = 1'b0;
        mem_rdy_i = 1'b0;
        step();
        chk("post_rst_idle", 0, {25'd0, ctl()}, 32'd0);

        // ---- dropped request on port 1 ----
        m1_req_i = 1'b1;
        step();
        chk("drop_issue", 0, {25'd0, ctl()}, {25'd0, 7'b0100010});
        m1_req_i = 1'b0;
        drive_cmds(1'b1);
        step();
        chk("drop_wait0", 0, {25'd0, ctl()}, {25'd0, 7'b0100000});
        step();
        chk("drop_wait1", 0, {25'd0, ctl()}, {25'd0, 7'b0100000});
        mem_rdy_i = 1'b1;
        mem_rd_i  = 32'hFEED_0001;
        step();
        chk("drop_ack", 0, {25'd0, ctl()}, {25'd0, 7'b0101000});
        chk("drop_rd", 0, rd_o, 32'h5555_AAAA);
        chk("drop_addr", 0, mem_addr_o, A1);
        mem_rdy_i = 1'b0;
        drive_cmds(1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("drop_no_regrant", i, {25'd0, ctl()}, 32'd0);
        end

        // ---- timeout on port 0 (TIMEOUT = 4): ack/err 6 cycles after grant ----
        m0_req_i  = 1'b1;
        mem_rdy_i = 1'b0;
        mem_rd_i  = 32'hFFFF_FFFF;
        step();
        chk("to_grant", 0, {25'd0, ctl()}, {25'd0, 7'b1000001});
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("to_cycle", i, {25'd0, ctl()},
                {25'd0, (i == 6) ? 7'b1010100 : 7'b1000000});
            if (i == 6) begin
                chk("to_rd", i, rd_o, 32'd0);
                m0_req_i = 1'b0;
            end
        end
        step();
        chk("to_idle", 0, {25'd0, ctl()}, 32'd0);
        chk("to_rd_hold", 0, rd_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
